// File: rtl/simm_dram_model.sv
// Behavioural SIMM DRAM model: decodes RAS/CAS/WE strobes sampled on clk, serves
// early-write / read / page-mode accesses and CBR refreshes, and flags timing violations.
module simm_dram_model #(
    parameter int MEM_AW      = 8,
    parameter int TRP_MIN     = 5,
    parameter int TRAS_MIN    = 5,
    parameter int REFRESH_MAX = 800
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [11:0] ram_addr,
    input  logic        ram_ras_,
    input  logic        ram_cas_,
    input  logic        ram_we_,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic        ram_doe,
    output logic [15:0] refresh_cnt,
    output logic        trp_err,
    output logic        tras_err,
    output logic        refresh_err
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] ROW_OPEN    = 3'd1;
    localparam logic [2:0] COL_ACCESS  = 3'd2;
    localparam logic [2:0] CBR_ARM     = 3'd3;
    localparam logic [2:0] CBR_REFRESH = 3'd4;

    localparam int              RW      = $clog2(REFRESH_MAX + 2);
    localparam logic [RW-1:0]   REF_LIM = RW'(REFRESH_MAX);
    localparam logic [15:0]     TRP_L   = 16'(TRP_MIN);
    localparam logic [15:0]     TRAS_L  = 16'(TRAS_MIN);

    logic [2:0]        state, state_nxt;
    logic [11:0]       row;
    logic              ras_q, cas_q;
    logic              primed;     // first sample after reset only seeds the edge detector
    logic              seen_fall;  // a ras_ fall has happened since reset
    logic [15:0]       hi_cnt, lo_cnt;
    logic [RW-1:0]     ref_int;
    logic [7:0]        mem [2**MEM_AW];

    logic              ras_fall, ras_rise, cas_fall, access, cbr_entry;
    logic [MEM_AW-1:0] idx;

    assign ras_fall  = primed & ras_q & ~ram_ras_;
    assign ras_rise  = primed & ~ras_q & ram_ras_;
    assign cas_fall  = primed & cas_q & ~ram_cas_;
    assign access    = (state == ROW_OPEN) & ~ram_ras_ & cas_fall;
    // Column is taken straight from ram_addr on the cas_-falling sample.
    assign idx       = MEM_AW'({row, ram_addr});
    assign cbr_entry = (state_nxt == CBR_REFRESH) & (state != CBR_REFRESH);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ras_fall)                            state_nxt = ram_cas_ ? ROW_OPEN : CBR_REFRESH;
                else if (primed & ~ram_cas_ & ram_ras_)  state_nxt = CBR_ARM;
            end
            CBR_ARM: begin
                if (ram_cas_)      state_nxt = ras_fall ? ROW_OPEN : IDLE;
                else if (ras_fall) state_nxt = CBR_REFRESH;
            end
            CBR_REFRESH: if (ram_ras_) state_nxt = IDLE;
            ROW_OPEN: begin
                if (ram_ras_)      state_nxt = IDLE;
                else if (cas_fall) state_nxt = COL_ACCESS;
            end
            COL_ACCESS: begin
                if (ram_ras_)      state_nxt = IDLE;
                else if (ram_cas_) state_nxt = ROW_OPEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            row         <= '0;
            ras_q       <= 1'b1;
            cas_q       <= 1'b1;
            primed      <= 1'b0;
            seen_fall   <= 1'b0;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            ref_int     <= '0;
            refresh_cnt <= '0;
            trp_err     <= 1'b0;
            tras_err    <= 1'b0;
            refresh_err <= 1'b0;
            ram_dout    <= '0;
            ram_doe     <= 1'b0;
        end else begin
            primed <= 1'b1;
            ras_q  <= ram_ras_;
            cas_q  <= ram_cas_;
            state  <= state_nxt;
            if (ras_fall & ram_cas_) row <= ram_addr;

            if (access & ram_we_) begin
                ram_dout <= mem[idx];
                ram_doe  <= 1'b1;
            end else if (ram_ras_ | ram_cas_) begin
                ram_doe  <= 1'b0;
            end

            // Flag is raised on the edge where the interval first exceeds the limit.
            if (cbr_entry) begin
                refresh_cnt <= refresh_cnt + 16'd1;
                ref_int     <= '0;
            end else begin
                if (ref_int != '1)     ref_int <= ref_int + 1'b1;
                if (ref_int >= REF_LIM) refresh_err <= 1'b1;
            end

            if (ras_fall) begin
                lo_cnt    <= 16'd1;
                seen_fall <= 1'b1;
                if (seen_fall && hi_cnt < TRP_L) trp_err <= 1'b1;
            end else if (ras_rise) begin
                hi_cnt <= 16'd1;
                if (seen_fall && lo_cnt < TRAS_L) tras_err <= 1'b1;
            end else if (!ram_ras_) begin
                if (lo_cnt != '1) lo_cnt <= lo_cnt + 16'd1;
            end else begin
                if (hi_cnt != '1) hi_cnt <= hi_cnt + 16'd1;
            end
        end
    end

    // Backing store is not reset; rst_ gating stops a write landing once reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_ && access && !ram_we_) mem[idx] <= ram_din;
    end
endmodule

// File: doc/simm_dram_model.md
SIMM_DRAM_MODEL -- requirements
Module: simm_dram_model

Interface
REQ-001 SHALL have parameters (name, default, meaning): MEM_AW, 8, backing-store address bits taken from {row,col} LSBs.
REQ-002 SHALL have parameter TRP_MIN, 5, minimum ras_ high (precharge) cycles.
REQ-003 SHALL have parameter TRAS_MIN, 5, minimum ras_ low cycles.
REQ-004 SHALL have parameter REFRESH_MAX, 800, maximum cycles allowed between CBR refreshes.
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock shared with the DRAM controller.
REQ-006 rst_, in, 1, reset; one clock; reset is asynchronous and active-low.
REQ-007 ram_addr, in, 12, multiplexed row/column address.
REQ-008 ram_ras_, ram_cas_, ram_we_, in, 1 each, active-low strobes.
REQ-009 ram_din, in, 8, write data from the controller.
REQ-010 ram_dout, out, 8, read data; ram_doe, out, 1, read-data drive enable.
REQ-011 refresh_cnt, out, 16, count of completed CBR refreshes, wrapping.
REQ-012 trp_err, tras_err, refresh_err, out, 1 each, sticky timing-violation flags.

Function
REQ-013 SHALL sample all strobes and ram_addr on posedge clk and compare with the previous sample to detect edges; no other input timing is assumed.
REQ-014 SHALL implement states IDLE, ROW_OPEN, COL_ACCESS, CBR_ARM and CBR_REFRESH.
REQ-015 IDLE, ras_ falling with cas_ high: SHALL latch row = ram_addr and go to ROW_OPEN.
REQ-016 IDLE, cas_ sampled low with ras_ high: SHALL go to CBR_ARM.
REQ-017 IDLE, ras_ and cas_ both falling on the same sample: SHALL be treated as CBR and go to CBR_REFRESH.
REQ-018 CBR_ARM, ras_ falling with cas_ still low: SHALL go to CBR_REFRESH.
REQ-019 CBR_ARM, cas_ rising before ras_ falls: SHALL return to IDLE with no count.
REQ-020 On entry to CBR_REFRESH, SHALL increment refresh_cnt once and clear the refresh-interval counter.
REQ-021 CBR_REFRESH SHALL exit to IDLE when ras_ is sampled high.
REQ-022 ROW_OPEN, cas_ falling: SHALL latch col = ram_addr and go to COL_ACCESS; index = {row,col}[MEM_AW-1:0].
REQ-023 Write (ram_we_ low at the cas_-falling sample): SHALL store ram_din at the index on that edge; ram_doe stays 0.
REQ-024 Read (ram_we_ high at the cas_-falling sample): on that edge SHALL load ram_dout with mem[index] and set ram_doe=1.
REQ-025 Read data SHALL therefore be valid one cycle after cas_ is first sampled low.
REQ-026 COL_ACCESS, cas_ rising with ras_ low: SHALL return to ROW_OPEN (page-mode re-access allowed).
REQ-027 ram_doe SHALL clear on the edge where cas_ or ras_ is sampled high; ram_dout SHALL hold its last value.
REQ-028 ras_ rising in ROW_OPEN or COL_ACCESS, including simultaneous ras_/cas_/we_ rise, SHALL go to IDLE.
REQ-029 tras_err SHALL set if ras_ rises after fewer than TRAS_MIN low cycles, applied to normal and CBR cycles alike.
REQ-030 trp_err SHALL set if ras_ falls after fewer than TRP_MIN high cycles; the check is skipped for the first ras_ fall after reset.
REQ-031 The refresh-interval counter SHALL saturate; refresh_err SHALL set when it exceeds REFRESH_MAX.
REQ-032 A timing violation SHALL NOT block the access or refresh; the operation completes normally.
REQ-033 Error flags SHALL be cleared only by reset.

Reset
REQ-034 rst_ low SHALL immediately force: state IDLE, ram_doe=0, ram_dout=0, refresh_cnt=0, all error flags 0, all counters 0, previous-sample strobes 1.
REQ-035 Backing memory SHALL NOT be cleared by reset.
REQ-036 Reset asserted mid-access SHALL abort the access with no memory write completing after rst_ falls.
REQ-037 After reset release, a strobe already low SHALL NOT be decoded as a falling edge.

Verification
REQ-038 Early write row=0x012 col=0x034 din=0xA5, then read of the same row/col -> ram_dout=0xA5 and ram_doe=1 one cycle after cas_ is sampled low; no error flags set.
REQ-039 Ten CBR cycles (cas_ low 1 cycle, ras_ low 3 cycles, then both high 5 cycles) -> refresh_cnt=10; refresh_err=0; tras_err=1 because ras_ low 3 < TRAS_MIN.
REQ-040 ras_ high only 3 cycles between two reads -> trp_err=1; the second read still returns correct data.
REQ-041 No CBR for 801 cycles after the last refresh -> refresh_err=1; it stays set after a later CBR.
REQ-042 cas_ low then high with ras_ held high -> refresh_cnt unchanged; state back to IDLE.
REQ-043 rst_ low while ram_doe=1 -> ram_doe=0 asynchronously; previously written data still readable after release.
